// File: rtl/data_packer.sv
// Packs a stream of 1b/4b/8b elements into LowDimWidth-wide words and buffers them
// in a small output FIFO. A full-width mode forwards each element as a word.
module data_packer #(
    parameter int unsigned LowDimWidth     = 64,
    parameter int unsigned PackerFifoDepth = 4,
    parameter int unsigned CsrDataWidth    = 32,
    parameter int unsigned ModeWidth       = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    enable_i,
    input  logic                    clr_i,
    input  logic [ModeWidth-1:0]    sel_mode_i,
    input  logic [CsrDataWidth-1:0] csr_elem_size_i,
    input  logic [LowDimWidth-1:0]  elem_data_i,
    input  logic                    elem_valid_i,
    output logic                    elem_ready_o,
    output logic [LowDimWidth-1:0]  packed_data_o,
    output logic                    packed_valid_o,
    input  logic                    packed_ready_i
);

    localparam int unsigned PtrW   = (PackerFifoDepth > 1) ? $clog2(PackerFifoDepth) : 1;
    localparam int unsigned CntW   = $clog2(PackerFifoDepth + 1);
    localparam int unsigned ChunkW = $clog2(LowDimWidth);

    localparam logic [ModeWidth-1:0] ModeBit  = ModeWidth'(1);
    localparam logic [ModeWidth-1:0] ModeNib  = ModeWidth'(2);
    localparam logic [ModeWidth-1:0] ModeByte = ModeWidth'(3);

    logic [LowDimWidth-1:0]  acc_q, acc_d;
    logic [ChunkW-1:0]       chunk_q, chunk_d;
    logic [CsrDataWidth-1:0] elem_cnt_q, elem_cnt_d;

    logic [LowDimWidth-1:0]  mem_q [PackerFifoDepth];
    logic [LowDimWidth-1:0]  mem_d [PackerFifoDepth];
    logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]         cnt_q, cnt_d;

    logic [LowDimWidth-1:0]  width_mask, slot, merged, push_data;
    logic [ChunkW-1:0]       last_slot, shamt;
    logic                    narrow, accept, pkt_end, word_done, push, pop, fifo_full;

    assign fifo_full      = (cnt_q == CntW'(PackerFifoDepth));
    assign elem_ready_o   = enable_i && !fifo_full;
    assign accept         = elem_valid_i && elem_ready_o;
    assign pop            = enable_i && packed_ready_i && (cnt_q != '0);
    assign packed_valid_o = (cnt_q != '0);
    assign packed_data_o  = mem_q[rd_ptr_q];

    // Slot geometry and merge of the incoming element into the accumulator
    always_comb begin
        width_mask = '1;
        last_slot  = '0;
        shamt      = '0;
        case (sel_mode_i)
            ModeBit: begin
                width_mask = LowDimWidth'(1);
                last_slot  = ChunkW'(LowDimWidth - 1);
                shamt      = chunk_q;
            end
            ModeNib: begin
                width_mask = LowDimWidth'(4'hF);
                last_slot  = ChunkW'(LowDimWidth / 4 - 1);
                shamt      = ChunkW'({chunk_q, 2'b00});
            end
            ModeByte: begin
                width_mask = LowDimWidth'(8'hFF);
                last_slot  = ChunkW'(LowDimWidth / 8 - 1);
                shamt      = ChunkW'({chunk_q, 3'b000});
            end
            default: ;
        endcase
        narrow    = (sel_mode_i != '0);
        slot      = (elem_data_i & width_mask) << shamt;
        merged    = acc_q | slot;
        pkt_end   = (csr_elem_size_i <= CsrDataWidth'(1)) ||
                    (elem_cnt_q == csr_elem_size_i - CsrDataWidth'(1));
        word_done = narrow ? ((chunk_q == last_slot) || pkt_end) : 1'b1;
        push      = accept && word_done;
        push_data = narrow ? merged : elem_data_i;
    end

    // Accumulator and counters; disable or clear drops any partial word
    always_comb begin
        acc_d      = acc_q;
        chunk_d    = chunk_q;
        elem_cnt_d = elem_cnt_q;
        if (!enable_i || clr_i) begin
            acc_d      = '0;
            chunk_d    = '0;
            elem_cnt_d = '0;
        end else if (accept && narrow) begin
            if (word_done) begin
                acc_d   = '0;
                chunk_d = '0;
            end else begin
                acc_d   = merged;
                chunk_d = chunk_q + ChunkW'(1);
            end
            elem_cnt_d = pkt_end ? '0 : elem_cnt_q + CsrDataWidth'(1);
        end
    end

    // Output FIFO pointers and storage; clear wins over a concurrent push
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d = (wr_ptr_q == PtrW'(PackerFifoDepth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PtrW'(PackerFifoDepth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CntW'(1);
                2'b01:   cnt_d = cnt_q - CntW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q      <= '0;
            chunk_q    <= '0;
            elem_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            for (int i = 0; i < int'(PackerFifoDepth); i++) mem_q[i] <= '0;
        end else begin
            acc_q      <= acc_d;
            chunk_q    <= chunk_d;
            elem_cnt_q <= elem_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            mem_q      <= mem_d;
        end
    end

endmodule

// File: tb/tb_data_packer.sv
// Self-checking bench for data_packer: table of element vectors feeding a scoreboard,
// plus hand-written sequences for latency, FIFO full, throughput, clear and reset.
module tb_data_packer;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        enable_i = 1'b0;
    logic        clr_i = 1'b0;
    logic [1:0]  sel_mode_i = 2'd0;
    logic [31:0] csr_elem_size_i = 32'd0;
    logic [63:0] elem_data_i = 64'd0;
    logic        elem_valid_i = 1'b0;
    logic        elem_ready_o;
    logic [63:0] packed_data_o;
    logic        packed_valid_o;
    logic        packed_ready_i = 1'b0;

    data_packer dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .enable_i        (enable_i),
        .clr_i           (clr_i),
        .sel_mode_i      (sel_mode_i),
        .csr_elem_size_i (csr_elem_size_i),
        .elem_data_i     (elem_data_i),
        .elem_valid_i    (elem_valid_i),
        .elem_ready_o    (elem_ready_o),
        .packed_data_o   (packed_data_o),
        .packed_valid_o  (packed_valid_o),
        .packed_ready_i  (packed_ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] csr;
        logic [63:0] data;
        bit          done;
        logic [63:0] word;
    } vec_t;

    vec_t        tbl[$];
    logic [63:0] exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic void add(input logic [1:0] m, input logic [31:0] c, input logic [63:0] d,
                                input bit dn, input logic [63:0] w);
        vec_t v;
        v.mode = m; v.csr = c; v.data = d; v.done = dn; v.word = w;
        tbl.push_back(v);
    endfunction

    // Scoreboard: compare every word popped by the downstream side
    always @(negedge clk_i) begin
        if (rst_ni && enable_i && !clr_i && packed_valid_o && packed_ready_i) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_word: got %h expected none", packed_data_o);
            end else begin
                check("packed_word", packed_data_o, exp_q.pop_front());
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input logic [63:0] d);
        int t = 0;
        elem_data_i  = d;
        elem_valid_i = 1'b1;
        @(negedge clk_i);
        while (!elem_ready_o && t < 50) begin
            @(negedge clk_i);
            t++;
        end
        if (!elem_ready_o) check("send_timeout", 64'(elem_ready_o), 64'd1);
        @(posedge clk_i); #1;
        elem_valid_i = 1'b0;
    endtask

    task automatic set_cfg(input logic [1:0] m, input logic [31:0] c);
        @(posedge clk_i); #1;
        enable_i = 1'b0;
        @(posedge clk_i); #1;
        sel_mode_i      = m;
        csr_elem_size_i = c;
        enable_i        = 1'b1;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge clk_i);
            t++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
        @(posedge clk_i); #1;
    endtask

    initial begin
        logic [63:0] w [4];
        logic [63:0] acc;

        // Vector table
        add(2'd1, 32'd3, 64'd1, 0, 0); add(2'd1, 32'd3, 64'd0, 0, 0); add(2'd1, 32'd3, 64'd1, 1, 64'h5);
        add(2'd1, 32'd3, 64'd1, 0, 0); add(2'd1, 32'd3, 64'd1, 0, 0); add(2'd1, 32'd3, 64'd1, 1, 64'h7);
        acc = 64'd0;
        for (int i = 0; i < 20; i++) begin
            acc = acc | (64'(i % 16) << (4 * (i % 16)));
            add(2'd2, 32'd20, 64'(i % 16) | 64'hF0, (i == 15) || (i == 19), acc);
            if (i == 15) acc = 64'd0;
        end
        acc = 64'd0;
        for (int i = 0; i < 64; i++) begin
            if (i % 3 == 0) acc = acc | (64'd1 << i);
            add(2'd1, 32'd100, 64'((i % 3) == 0) | 64'h2, i == 63, acc);
        end
        add(2'd3, 32'd1, 64'h12AB, 1, 64'hAB); add(2'd3, 32'd1, 64'h34CD, 1, 64'hCD);
        add(2'd2, 32'd0, 64'h7, 1, 64'h7);     add(2'd2, 32'd0, 64'h1F, 1, 64'hF);

        // Reset state
        #12;
        check("rst_valid", 64'(packed_valid_o), 64'd0);
        check("rst_data", packed_data_o, 64'd0);
        check("rst_ready", 64'(elem_ready_o), 64'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("post_rst_valid", 64'(packed_valid_o), 64'd0);

        // 8b latency: word appears just after the 8th accept
        set_cfg(2'd3, 32'd8);
        for (int i = 1; i <= 7; i++) send(64'(i));
        @(negedge clk_i);
        check("lat_valid_before", 64'(packed_valid_o), 64'd0);
        @(posedge clk_i); #1;
        exp_q.push_back(64'h0807060504030201);
        send(64'd8);
        @(negedge clk_i);
        check("lat_valid_after", 64'(packed_valid_o), 64'd1);
        check("lat_data", packed_data_o, 64'h0807060504030201);
        @(posedge clk_i); #1;
        packed_ready_i = 1'b1;
        drain();

        // Table-driven vectors
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].mode != sel_mode_i || tbl[i].csr != csr_elem_size_i)
                set_cfg(tbl[i].mode, tbl[i].csr);
            if (tbl[i].done) exp_q.push_back(tbl[i].word);
            send(tbl[i].data);
        end
        drain();

        // FIFO full in passthrough mode
        set_cfg(2'd0, 32'd0);
        packed_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(64'hA000 + 64'(i));
            send(64'hA000 + 64'(i));
        end
        exp_q.push_back(64'hA004);
        elem_data_i  = 64'hA004;
        elem_valid_i = 1'b1;
        @(negedge clk_i);
        check("full_ready_low", 64'(elem_ready_o), 64'd0);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("full_ready_hold", 64'(elem_ready_o), 64'd0);
        check("full_head", packed_data_o, 64'hA000);
        @(posedge clk_i); #1;
        packed_ready_i = 1'b1;
        @(negedge clk_i);
        check("full_ready_pop_cycle", 64'(elem_ready_o), 64'd0);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("full_ready_reraised", 64'(elem_ready_o), 64'd1);
        @(posedge clk_i); #1;
        elem_valid_i = 1'b0;
        drain();

        // Passthrough full throughput, 1-cycle latency
        w[0] = 64'hDEADBEEFCAFEF00D; w[1] = 64'h0123456789ABCDEF;
        w[2] = 64'hFFFF0000FFFF0000; w[3] = 64'h5555AAAA5555AAAA;
        for (int i = 0; i < 4; i++) begin
            elem_valid_i = 1'b1;
            elem_data_i  = w[i];
            exp_q.push_back(w[i]);
            @(negedge clk_i);
            check("thru_ready", 64'(elem_ready_o), 64'd1);
            if (i > 0) check("thru_data", packed_data_o, w[i-1]);
            @(posedge clk_i); #1;
        end
        elem_valid_i = 1'b0;
        @(negedge clk_i);
        check("thru_last", packed_data_o, w[3]);
        @(posedge clk_i); #1;
        drain();

        // Clear discards a partial word
        set_cfg(2'd3, 32'd8);
        for (int i = 0; i < 3; i++) send(64'hE0 + 64'(i));
        clr_i = 1'b1;
        @(posedge clk_i); #1;
        clr_i = 1'b0;
        exp_q.push_back(64'h8877665544332211);
        for (int i = 1; i <= 8; i++) send(64'h11 * 64'(i));
        drain();

        // Enable low discards a partial word
        for (int i = 0; i < 5; i++) send(64'hC0 + 64'(i));
        enable_i = 1'b0;
        @(posedge clk_i); #1;
        enable_i = 1'b1;
        exp_q.push_back(64'h0F0E0D0C0B0A0908);
        for (int i = 8; i < 16; i++) send(64'(i));
        drain();

        // Reset mid-word loses the partial word
        for (int i = 0; i < 3; i++) send(64'hF0 + 64'(i));
        rst_ni = 1'b0;
        #1;
        check("midrst_valid", 64'(packed_valid_o), 64'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        exp_q.push_back(64'h2827262524232221);
        for (int i = 1; i <= 8; i++) send(64'h20 + 64'(i));
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
